// File: rtl/byte_div_pkg.sv
// byte_div_pkg: shared types and constants for the byte divider.
package byte_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int          ITER_COUNT  = 8;
   localparam int          CNT_W       = $clog2(ITER_COUNT + 1);
   localparam logic [7:0]  DZ_QUOT_DEF = 8'hFF;

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t CNT_LAST = cnt_t'(ITER_COUNT - 1);

endpackage

// File: rtl/byte_subtractor.sv
// byte_subtractor: combinational a - b - bin, built as a + ~b + ~bin.
// bout is high when the subtraction borrows (carry out of the sum is low).
module byte_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   logic [WIDTH:0] sum;

   // Add the inverted subtrahend; carry-in of ~bin supplies the two's-complement +1.
   always_comb begin
      sum  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, ~bin};
      diff = sum[WIDTH-1:0];
      bout = ~sum[WIDTH];
   end

endmodule

// File: rtl/byte_divider.sv
// byte_divider: multi-cycle restoring divider, one trial subtraction per cycle.
// Start/done handshake; quotient and remainder are held until the next accept.
// Optional feature: define BYTE_DIV_SIGNED_EN to honour signed_op (two's complement).
module byte_divider
   import byte_div_pkg::*;
#(
   parameter int unsigned      WIDTH   = 8,
   parameter logic [WIDTH-1:0] DZ_QUOT = DZ_QUOT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             signed_op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? (~v + WIDTH'(1)) : v;
   endfunction

   state_t           state_q,     state_d;
   cnt_t             cnt_q,       cnt_d;
   logic [WIDTH-1:0] r_q,         r_d;          // partial remainder
   logic [WIDTH-1:0] q_q,         q_d;          // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] d_q,         d_d;          // divisor magnitude
   logic             neg_quot_q,  neg_quot_d;
   logic             neg_rem_q,   neg_rem_d;
   logic [WIDTH-1:0] quotient_q,  quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             div_zero_q,  div_zero_d;

   logic             sgn_en;
   logic [WIDTH:0]   rs;
   logic [WIDTH-1:0] r_step, q_step, sub_diff;
   logic             sub_bout;

`ifdef BYTE_DIV_SIGNED_EN
   assign sgn_en = signed_op;
`else
   logic unused_signed_op;
   assign unused_signed_op = signed_op;
   assign sgn_en           = 1'b0;
`endif

   byte_subtractor #(.WIDTH(WIDTH)) u_sub (
      .a    (rs[WIDTH-1:0]),
      .b    (d_q),
      .bin  (1'b0),
      .diff (sub_diff),
      .bout (sub_bout)
   );

   // One restoring-division step: shift, trial-subtract, keep the difference if it fits.
   always_comb begin
      rs     = {r_q, q_q[WIDTH-1]};
      q_step = {q_q[WIDTH-2:0], 1'b0};
      r_step = rs[WIDTH-1:0];
      if (rs[WIDTH] | ~sub_bout) begin
         r_step    = sub_diff;
         q_step[0] = 1'b1;
      end
   end

   // Next-state and datapath control for the IDLE/CALC/DONE sequence.
   always_comb begin
      // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
      state_d     = state_q;
      cnt_d       = cnt_q;
      r_d         = r_q;
      q_d         = q_q;
      d_d         = d_q;
      neg_quot_d  = neg_quot_q;
      neg_rem_d   = neg_rem_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d      = '0;
               r_d        = '0;
               q_d        = cond_neg(dividend, sgn_en & dividend[WIDTH-1]);
               d_d        = cond_neg(divisor,  sgn_en & divisor[WIDTH-1]);
               neg_quot_d = sgn_en & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
               neg_rem_d  = sgn_en & dividend[WIDTH-1];
               div_zero_d = 1'b0;
               if (divisor == '0) begin
                  // Divide-by-zero skips CALC; the raw dividend is returned as remainder.
                  state_d     = DONE;
                  quotient_d  = DZ_QUOT;
                  remainder_d = dividend;
                  div_zero_d  = 1'b1;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            r_d   = r_step;
            q_d   = q_step;
            cnt_d = cnt_q + cnt_t'(1);
            if (cnt_q == CNT_LAST) begin
               // Results (with sign fix-up) are published only on the final step.
               state_d     = DONE;
               quotient_d  = cond_neg(q_step, neg_quot_q);
               remainder_d = cond_neg(r_step, neg_rem_q);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous reset; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         // NOTE: datapath registers are reset too, so outputs are defined straight out of reset.
         state_q     <= IDLE;
         cnt_q       <= '0;
         r_q         <= '0;
         q_q         <= '0;
         d_q         <= '0;
         neg_quot_q  <= 1'b0;
         neg_rem_q   <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         r_q         <= r_d;
         q_q         <= q_d;
         d_q         <= d_d;
         neg_quot_q  <= neg_quot_d;
         neg_rem_q   <= neg_rem_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         div_zero_q  <= div_zero_d;
      end
   end

   assign busy      = (state_q == CALC);
   assign done      = (state_q == DONE);
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_byte_divider.sv
// tb_byte_divider: scoreboard bench for byte_divider.
// Honours BYTE_DIV_SIGNED_EN the same way the design does.
module tb_byte_divider;

   typedef struct packed {
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
   } exp_t;

`ifdef BYTE_DIV_SIGNED_EN
   localparam bit SGN_EN = 1'b1;
`else
   localparam bit SGN_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       signed_op;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_zero;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_done   = 0;
   int   n_ops    = 0;
   logic done_prev = 1'b0;
   logic [7:0] last_q = '0;
   logic [7:0] last_r = '0;
   exp_t sb[$];

   byte_divider dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .signed_op (signed_op),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic sg);
      exp_t e;
      int   sa, sbv;
      if (b == 8'h00) begin
         e.q = 8'hFF; e.r = a; e.dz = 1'b1;
      end else if (SGN_EN && sg) begin
         sa  = $signed(a);
         sbv = $signed(b);
         e.q = 8'(sa / sbv);
         e.r = 8'(sa % sbv);
         e.dz = 1'b0;
      end else begin
         e.q = a / b; e.r = a % b; e.dz = 1'b0;
      end
      return e;
   endfunction

   // Monitor: pop the scoreboard on every done pulse, away from the rising edge.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && done) begin
         n_done++;
         check("done_one_cycle", done_prev, 1'b0);
         if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
            check("div_zero", div_zero, e.dz);
         end
      end
      done_prev <= done;
   end

   // One accepted operation; hold=1 keeps start high with other operands until done.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sg,
                        input exp_t e, input bit hold);
      int cyc, busy_cnt;
      sb.push_back(e);
      n_ops++;
      @(negedge clk);
      dividend = a; divisor = b; signed_op = sg; start = 1'b1;
      @(posedge clk);
      #1;
      if (hold) begin
         dividend = 8'd50; divisor = 8'd5;
      end else begin
         start = 1'b0;
      end
      cyc = 0; busy_cnt = 0;
      while (cyc < 30) begin
         @(negedge clk);
         cyc++;
         if (busy) busy_cnt++;
         if (busy && busy_cnt == 4)
            check("hold_mid_op", {quotient, remainder}, {last_q, last_r});
         if (done) break;
      end
      start = 1'b0;
      check("latency", cyc, e.dz ? 1 : 9);
      check("busy_cycles", busy_cnt, e.dz ? 0 : 8);
      last_q = e.q; last_r = e.r;
      @(negedge clk);
      check("hold_after", {quotient, remainder, div_zero}, {e.q, e.r, e.dz});
   endtask

   task automatic do_model(input logic [7:0] a, input logic [7:0] b, input logic sg);
      do_op(a, b, sg, model(a, b, sg), 1'b0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0; signed_op = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_results", {quotient, remainder, div_zero}, 17'h0);
      rst = 1'b0;

      // Basic operation and divide-by-zero.
      do_op(8'd200, 8'd7, 1'b0, '{8'h1C, 8'h04, 1'b0}, 1'b0);
      do_op(8'd13,  8'd0, 1'b0, '{8'hFF, 8'h0D, 1'b1}, 1'b0);

      // start held high through CALC and DONE: only one result.
      do_op(8'd200, 8'd7, 1'b0, '{8'h1C, 8'h04, 1'b0}, 1'b1);
      repeat (12) @(negedge clk);
      check("held_start_one_result", n_done, n_ops);

      // Reset on CALC edge 4 aborts the operation.
      @(negedge clk);
      dividend = 8'd200; divisor = 8'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_results", {quotient, remainder}, 16'h0);
      last_q = '0; last_r = '0;
      do_op(8'd100, 8'd10, 1'b0, '{8'h0A, 8'h00, 1'b0}, 1'b0);

      // Boundary values.
      do_op(8'd255, 8'd1,   1'b0, '{8'hFF, 8'h00, 1'b0}, 1'b0);
      do_op(8'd5,   8'd9,   1'b0, '{8'h00, 8'h05, 1'b0}, 1'b0);
      do_op(8'd255, 8'd255, 1'b0, '{8'h01, 8'h00, 1'b0}, 1'b0);

`ifdef BYTE_DIV_SIGNED_EN
      do_op(8'hF9, 8'h02, 1'b1, '{8'hFD, 8'hFF, 1'b0}, 1'b0);
      do_op(8'h80, 8'hFF, 1'b1, '{8'h80, 8'h00, 1'b0}, 1'b0);
      do_op(8'hF9, 8'h00, 1'b1, '{8'hFF, 8'hF9, 1'b1}, 1'b0);
`else
      do_op(8'hF9, 8'h02, 1'b0, '{8'h7C, 8'h01, 1'b0}, 1'b0);
      do_op(8'hF9, 8'h02, 1'b1, '{8'h7C, 8'h01, 1'b0}, 1'b0);
`endif

      // Random operations against the model.
      for (int i = 0; i < 24; i++) begin
         logic [7:0] a, b;
         a = 8'($urandom_range(0, 255));
         b = (i % 8 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
         do_model(a, b, 1'($urandom_range(0, 1)));
      end

      repeat (12) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      check("done_count", n_done, n_ops);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
